// File: rtl/csi_lane_merge.sv
// -----------------------------------------------------------------------------
// csi_lane_merge
//   Deskews four D-PHY HS byte lanes on their start-of-transmission markers and
//   merges them into 32-bit words for the CSI-2 header/payload resolver.
//   Lane 0 lands in data[7:0], lane 3 in data[31:24].
//
// Ports
//   clk         in   byte clock, all lanes synchronous to it
//   rstn        in   asynchronous active-low reset
//   lane_byte   in   [31:0] packed lane bytes, lane i at [8i+7:8i]
//   lane_valid  in   [3:0] per-lane byte strobe
//   lane_sot    in   [3:0] per-lane SoT pulse, coincident with first byte
//   hs_mode     in   [3:0] per-lane HS-active level
//   data        out  [31:0] merged word
//   byte_gate   out  [3:0] 4'b1111 for exactly the cycles data is valid
//   found_sot   out  [3:0] 4'b1111 while streaming
//   data_offs   out  [8:0] index of current word since SoT, saturates at 511
//   skew_err    out  one-cycle pulse, lanes not aligned within SKEW_MAX
//   ovf_err     out  one-cycle pulse, push into a full lane FIFO
// -----------------------------------------------------------------------------
module csi_lane_merge #(
    parameter int SKEW_MAX = 3,
    parameter int DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] lane_byte,
    input  logic [3:0]  lane_valid,
    input  logic [3:0]  lane_sot,
    input  logic [3:0]  hs_mode,
    output logic [31:0] data,
    output logic [3:0]  byte_gate,
    output logic [3:0]  found_sot,
    output logic [8:0]  data_offs,
    output logic        skew_err,
    output logic        ovf_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(SKEW_MAX + 2);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_STREAM = 2'd2,
        ST_ERR    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      sot_seen_q, sot_seen_d;
    logic [SW-1:0]   skew_cnt_q, skew_cnt_d;
    logic [8:0]      word_cnt_q, word_cnt_d;

    logic [7:0]      mem_q    [4][DEPTH];
    logic [AW-1:0]   wr_ptr_q [4];
    logic [AW-1:0]   rd_ptr_q [4];
    logic [CW-1:0]   cnt_q    [4];

    logic [31:0]     data_q, data_d;
    logic [3:0]      byte_gate_q, byte_gate_d;
    logic [3:0]      found_sot_q, found_sot_d;
    logic [8:0]      data_offs_q, data_offs_d;
    logic            skew_err_q, skew_err_d;
    logic            ovf_err_q, ovf_err_d;

    logic [3:0]      full_s;
    logic [3:0]      nempty_s;
    logic [31:0]     head_s;
    logic [3:0]      push_req_s;
    logic [3:0]      wr_en_s;
    logic            pop_s;
    logic            flush_s;
    logic            ovf_s;
    logic [3:0]      seen_now_s;

    // FIFO status flags and the byte at the head of each lane FIFO
    always_comb begin
        full_s   = 4'b0000;
        nempty_s = 4'b0000;
        head_s   = 32'd0;
        for (int i = 0; i < 4; i++) begin
            full_s[i]         = (cnt_q[i] == CW'(DEPTH));
            nempty_s[i]       = (cnt_q[i] != CW'(0));
            head_s[8*i +: 8]  = mem_q[i][rd_ptr_q[i]];
        end
    end

    // Next-state, FIFO control and output-register next values
    always_comb begin
        state_d     = state_q;
        sot_seen_d  = sot_seen_q;
        skew_cnt_d  = skew_cnt_q;
        word_cnt_d  = word_cnt_q;
        data_d      = data_q;
        byte_gate_d = 4'b0000;
        data_offs_d = data_offs_q;
        skew_err_d  = 1'b0;
        ovf_err_d   = 1'b0;
        push_req_s  = 4'b0000;
        pop_s       = 1'b0;
        flush_s     = 1'b0;
        ovf_s       = 1'b0;
        seen_now_s  = sot_seen_q | (lane_sot & lane_valid);

        case (state_q)
            ST_IDLE: begin
                word_cnt_d = 9'd0;
                if ((lane_sot & lane_valid) != 4'b0000) begin
                    sot_seen_d = lane_sot & lane_valid;
                    push_req_s = lane_sot & lane_valid;
                    // The SoT cycle itself counts as the first skew cycle.
                    skew_cnt_d = SW'(1);
                    state_d    = ST_ALIGN;
                end else begin
                    sot_seen_d = 4'b0000;
                    skew_cnt_d = SW'(0);
                    flush_s    = 1'b1;
                end
            end

            ST_ALIGN: begin
                if (hs_mode != 4'b1111) begin
                    // End of burst wins over any error raised this cycle.
                    state_d    = ST_IDLE;
                    flush_s    = 1'b1;
                    sot_seen_d = 4'b0000;
                    skew_cnt_d = SW'(0);
                    word_cnt_d = 9'd0;
                end else begin
                    sot_seen_d = seen_now_s;
                    push_req_s = lane_valid & seen_now_s;
                    ovf_s      = ((push_req_s & full_s) != 4'b0000);
                    if ((seen_now_s != 4'b1111) && (skew_cnt_q == SW'(SKEW_MAX))) begin
                        skew_err_d = 1'b1;
                        state_d    = ST_ERR;
                    end else if (ovf_s) begin
                        ovf_err_d  = 1'b1;
                        state_d    = ST_ERR;
                    end else if (seen_now_s == 4'b1111) begin
                        skew_cnt_d = SW'(0);
                        state_d    = ST_STREAM;
                    end else begin
                        skew_cnt_d = skew_cnt_q + SW'(1);
                    end
                end
            end

            ST_STREAM: begin
                if (hs_mode != 4'b1111) begin
                    state_d    = ST_IDLE;
                    flush_s    = 1'b1;
                    sot_seen_d = 4'b0000;
                    word_cnt_d = 9'd0;
                end else begin
                    pop_s      = (nempty_s == 4'b1111);
                    push_req_s = lane_valid & sot_seen_q;
                    // A full lane that is popped this cycle can still accept.
                    ovf_s      = ((push_req_s & full_s & ~{4{pop_s}}) != 4'b0000);
                    if (pop_s) begin
                        data_d      = head_s;
                        byte_gate_d = 4'b1111;
                        data_offs_d = word_cnt_q;
                        if (word_cnt_q != 9'd511) begin
                            word_cnt_d = word_cnt_q + 9'd1;
                        end else begin
                            word_cnt_d = word_cnt_q;
                        end
                    end else begin
                        byte_gate_d = 4'b0000;
                    end
                    if (ovf_s) begin
                        ovf_err_d = 1'b1;
                        state_d   = ST_ERR;
                    end else begin
                        state_d   = ST_STREAM;
                    end
                end
            end

            ST_ERR: begin
                flush_s    = 1'b1;
                sot_seen_d = 4'b0000;
                skew_cnt_d = SW'(0);
                word_cnt_d = 9'd0;
                if (hs_mode == 4'b0000) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ERR;
                end
            end

            default: begin
                state_d    = ST_IDLE;
                flush_s    = 1'b1;
                sot_seen_d = 4'b0000;
                skew_cnt_d = SW'(0);
                word_cnt_d = 9'd0;
            end
        endcase

        // Offending bytes into a full, unpopped FIFO are dropped.
        wr_en_s = push_req_s & (~full_s | {4{pop_s}});

        if (state_d == ST_STREAM) begin
            found_sot_d = 4'b1111;
        end else begin
            found_sot_d = 4'b0000;
            data_offs_d = 9'd0;
        end
    end

    // State, lane FIFOs and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            sot_seen_q  <= 4'b0000;
            skew_cnt_q  <= SW'(0);
            word_cnt_q  <= 9'd0;
            data_q      <= 32'd0;
            byte_gate_q <= 4'b0000;
            found_sot_q <= 4'b0000;
            data_offs_q <= 9'd0;
            skew_err_q  <= 1'b0;
            ovf_err_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                wr_ptr_q[i] <= AW'(0);
                rd_ptr_q[i] <= AW'(0);
                cnt_q[i]    <= CW'(0);
                for (int j = 0; j < DEPTH; j++) begin
                    mem_q[i][j] <= 8'd0;
                end
            end
        end else begin
            state_q     <= state_d;
            sot_seen_q  <= sot_seen_d;
            skew_cnt_q  <= skew_cnt_d;
            word_cnt_q  <= word_cnt_d;
            data_q      <= data_d;
            byte_gate_q <= byte_gate_d;
            found_sot_q <= found_sot_d;
            data_offs_q <= data_offs_d;
            skew_err_q  <= skew_err_d;
            ovf_err_q   <= ovf_err_d;
            for (int i = 0; i < 4; i++) begin
                if (flush_s) begin
                    wr_ptr_q[i] <= AW'(0);
                    rd_ptr_q[i] <= AW'(0);
                    cnt_q[i]    <= CW'(0);
                end else begin
                    if (wr_en_s[i]) begin
                        mem_q[i][wr_ptr_q[i]] <= lane_byte[8*i +: 8];
                        wr_ptr_q[i]           <= wr_ptr_q[i] + AW'(1);
                    end
                    if (pop_s) begin
                        rd_ptr_q[i] <= rd_ptr_q[i] + AW'(1);
                    end
                    cnt_q[i] <= cnt_q[i] + CW'(wr_en_s[i]) - CW'(pop_s);
                end
            end
        end
    end

    assign data      = data_q;
    assign byte_gate = byte_gate_q;
    assign found_sot = found_sot_q;
    assign data_offs = data_offs_q;
    assign skew_err  = skew_err_q;
    assign ovf_err   = ovf_err_q;

endmodule

// File: tb/tb_csi_lane_merge.sv
// -----------------------------------------------------------------------------
// tb_csi_lane_merge
//   Drives per-lane byte bursts (directed and $urandom) into csi_lane_merge and
//   compares every output each cycle against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_csi_lane_merge;

    localparam int SKEW_MAX = 3;
    localparam int DEPTH    = 4;
    localparam int M_IDLE = 0, M_ALIGN = 1, M_STREAM = 2, M_ERR = 3;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] lane_byte;
    logic [3:0]  lane_valid, lane_sot, hs_mode;
    logic [31:0] data;
    logic [3:0]  byte_gate, found_sot;
    logic [8:0]  data_offs;
    logic        skew_err, ovf_err;

    csi_lane_merge #(.SKEW_MAX(SKEW_MAX), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .lane_byte(lane_byte), .lane_valid(lane_valid),
        .lane_sot(lane_sot), .hs_mode(hs_mode), .data(data), .byte_gate(byte_gate),
        .found_sot(found_sot), .data_offs(data_offs), .skew_err(skew_err), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // reference model state
    int          m_state;
    logic [7:0]  mq [4][$];
    logic [3:0]  m_seen;
    int          m_skew;
    int          m_wcnt;
    logic [31:0] e_data;
    logic [3:0]  e_bg, e_fs;
    logic [8:0]  e_offs;
    logic        e_skew, e_ovf;

    // observations of the current burst
    logic [31:0] obs_data [$];
    int          obs_offs [$];
    int          n_skew_seen, n_ovf_seen;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] seq_word(input int idx);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = 8'((idx * 4 + i + 1) * 17);
        return w;
    endfunction

    function automatic logic [31:0] obs_at(input int idx);
        return (idx < obs_data.size()) ? obs_data[idx] : 32'hDEAD_BEEF;
    endfunction

    function automatic int offs_at(input int idx);
        return (idx < obs_offs.size()) ? obs_offs[idx] : -1;
    endfunction

    task automatic model_reset();
        m_state = M_IDLE;
        for (int i = 0; i < 4; i++) mq[i].delete();
        m_seen = 4'b0000; m_skew = 0; m_wcnt = 0;
        e_data = 32'd0; e_bg = 4'b0000; e_fs = 4'b0000; e_offs = 9'd0;
        e_skew = 1'b0; e_ovf = 1'b0;
    endtask

    // One clock of the behavioural rules, applied to the inputs of that cycle.
    task automatic model_step(input logic [31:0] b, input logic [3:0] v,
                              input logic [3:0] s, input logic [3:0] hs);
        int nxt;
        bit ovf, pop;
        logic [31:0] w;
        nxt = m_state; ovf = 0; pop = 0;
        e_bg = 4'b0000; e_skew = 1'b0; e_ovf = 1'b0;
        case (m_state)
            M_IDLE: begin
                if ((s & v) != 4'b0000) begin
                    m_seen = s & v;
                    for (int i = 0; i < 4; i++) if (m_seen[i]) mq[i].push_back(b[8*i +: 8]);
                    m_skew = 1;
                    nxt = M_ALIGN;
                end
            end
            M_ALIGN: begin
                if (hs != 4'b1111) nxt = M_IDLE;
                else begin
                    m_seen = m_seen | (s & v);
                    for (int i = 0; i < 4; i++)
                        if (v[i] && m_seen[i]) begin
                            if (mq[i].size() == DEPTH) ovf = 1;
                            else mq[i].push_back(b[8*i +: 8]);
                        end
                    if (m_seen != 4'b1111 && m_skew == SKEW_MAX) begin e_skew = 1'b1; nxt = M_ERR; end
                    else if (ovf) begin e_ovf = 1'b1; nxt = M_ERR; end
                    else if (m_seen == 4'b1111) begin m_skew = 0; nxt = M_STREAM; end
                    else m_skew++;
                end
            end
            M_STREAM: begin
                if (hs != 4'b1111) nxt = M_IDLE;
                else begin
                    pop = 1;
                    for (int i = 0; i < 4; i++) if (mq[i].size() == 0) pop = 0;
                    if (pop) begin
                        for (int i = 0; i < 4; i++) w[8*i +: 8] = mq[i].pop_front();
                        e_data = w; e_bg = 4'b1111; e_offs = 9'(m_wcnt);
                        if (m_wcnt < 511) m_wcnt++;
                    end
                    for (int i = 0; i < 4; i++)
                        if (v[i] && m_seen[i]) begin
                            if (mq[i].size() == DEPTH) ovf = 1;
                            else mq[i].push_back(b[8*i +: 8]);
                        end
                    if (ovf) begin e_ovf = 1'b1; nxt = M_ERR; end
                end
            end
            default: begin
                if (hs == 4'b0000) nxt = M_IDLE;
            end
        endcase
        if (nxt == M_IDLE || nxt == M_ERR) begin
            for (int i = 0; i < 4; i++) mq[i].delete();
            m_seen = 4'b0000; m_skew = 0; m_wcnt = 0;
        end
        m_state = nxt;
        e_fs = (nxt == M_STREAM) ? 4'b1111 : 4'b0000;
        if (nxt != M_STREAM) e_offs = 9'd0;
    endtask

    task automatic chk_outputs();
        check_eq("data",      data,      e_data);
        check_eq("byte_gate", 32'(byte_gate), 32'(e_bg));
        check_eq("found_sot", 32'(found_sot), 32'(e_fs));
        check_eq("data_offs", 32'(data_offs), 32'(e_offs));
        check_eq("skew_err",  32'(skew_err),  32'(e_skew));
        check_eq("ovf_err",   32'(ovf_err),   32'(e_ovf));
        if (byte_gate === 4'b1111) begin
            obs_data.push_back(data);
            obs_offs.push_back(int'(data_offs));
        end
        if (skew_err === 1'b1) n_skew_seen++;
        if (ovf_err === 1'b1) n_ovf_seen++;
    endtask

    task automatic cyc(input logic [31:0] b, input logic [3:0] v,
                       input logic [3:0] s, input logic [3:0] hs);
        @(negedge clk);
        chk_outputs();
        lane_byte = b; lane_valid = v; lane_sot = s; hs_mode = hs;
        model_step(b, v, s, hs);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        chk_outputs();
        #2 rstn = 1'b0;
        #1;
        check_eq("rst_data", data, 32'd0);
        check_eq("rst_gate", 32'(byte_gate), 32'd0);
        check_eq("rst_fsot", 32'(found_sot), 32'd0);
        check_eq("rst_offs", 32'(data_offs), 32'd0);
        lane_byte = 32'd0; lane_valid = 4'b0000; lane_sot = 4'b0000; hs_mode = 4'b0000;
        model_reset();
        @(negedge clk);
        chk_outputs();
        rstn = 1'b1;
        model_step(32'd0, 4'b0000, 4'b0000, 4'b0000);
    endtask

    // st: 4-bit start cycle per lane; gl/ga/glen: gap lane, gap position, gap length
    task automatic burst(input logic [15:0] st, input int nb, input int gl, input int ga,
                         input int glen, input int hs_len, input logic [3:0] hs_after,
                         input int rst_at, input bit seq);
        logic [31:0] bb;
        logic [3:0]  vv, ss, hs;
        int rel, idx;
        bit ingap;
        obs_data.delete(); obs_offs.delete();
        n_skew_seen = 0; n_ovf_seen = 0;
        for (int c = 0; c < hs_len + 4; c++) begin
            if (c == rst_at) begin
                mid_reset();
                break;
            end
            hs = (c < hs_len) ? 4'b1111 : ((c == hs_len) ? hs_after : 4'b0000);
            for (int i = 0; i < 4; i++) begin
                rel = c - int'(st[4*i +: 4]);
                idx = rel; ingap = 0;
                if (i == gl && rel >= ga) begin
                    if (rel < ga + glen) ingap = 1;
                    else idx = rel - glen;
                end
                vv[i] = hs[i] && !ingap && rel >= 0 && idx >= 0 && idx < nb;
                ss[i] = vv[i] && (idx == 0);
                bb[8*i +: 8] = seq ? 8'((idx * 4 + i + 1) * 17) : 8'($urandom);
            end
            cyc(bb, vv, ss, hs);
        end
    endtask

    initial begin
        int gl, mx, hl, ra;
        logic [15:0] st;
        rstn = 1'b0;
        lane_byte = 32'd0; lane_valid = 4'b0000; lane_sot = 4'b0000; hs_mode = 4'b0000;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk_outputs();
        rstn = 1'b1;
        model_step(32'd0, 4'b0000, 4'b0000, 4'b0000);

        // aligned SoT on all lanes
        burst(16'h0000, 8, -1, 0, 0, 12, 4'b0000, -1, 1'b1);
        check_eq("s1_words", 32'(obs_data.size()), 32'd8);
        check_eq("s1_first", obs_at(0), 32'h4433_2211);
        check_eq("s1_second", obs_at(1), 32'h8877_6655);
        check_eq("s1_offs0", 32'(offs_at(0)), 32'd0);
        check_eq("s1_offs1", 32'(offs_at(1)), 32'd1);

        // lane 3 three cycles late: still within SKEW_MAX
        burst(16'h3000, 8, -1, 0, 0, 16, 4'b0000, -1, 1'b1);
        check_eq("s2_skew", 32'(n_skew_seen), 32'd0);
        check_eq("s2_words", 32'(obs_data.size()), 32'd8);
        check_eq("s2_first", obs_at(0), 32'h4433_2211);

        // lane 2 five cycles late: skew error, no data
        burst(16'h0500, 8, -1, 0, 0, 12, 4'b0000, -1, 1'b1);
        check_eq("s3_skew", 32'(n_skew_seen), 32'd1);
        check_eq("s3_words", 32'(obs_data.size()), 32'd0);
        burst(16'h0000, 4, -1, 0, 0, 10, 4'b0000, -1, 1'b1);
        check_eq("s3_recover", obs_at(0), 32'h4433_2211);

        // lane 1 pauses 2 cycles: absorbed by the FIFOs
        burst(16'h0000, 10, 1, 2, 2, 20, 4'b0000, -1, 1'b1);
        check_eq("s4_ovf", 32'(n_ovf_seen), 32'd0);
        check_eq("s4_words", 32'(obs_data.size()), 32'd10);
        check_eq("s4_last", obs_at(9), seq_word(9));

        // lane 1 pauses 5 cycles: overflow
        burst(16'h0000, 10, 1, 2, 5, 20, 4'b0000, -1, 1'b1);
        check_eq("s4b_ovf", 32'(n_ovf_seen), 32'd1);

        // hs_mode[0] drops with bytes buffered on the early lanes
        burst(16'h2000, 20, -1, 0, 0, 6, 4'b1110, -1, 1'b1);

        // reset mid-stream, then a fresh burst starts from offset 0
        burst(16'h0000, 10, -1, 0, 0, 14, 4'b0000, 6, 1'b1);
        burst(16'h0000, 4, -1, 0, 0, 10, 4'b0000, -1, 1'b1);
        check_eq("s6_first", obs_at(0), 32'h4433_2211);
        check_eq("s6_offs0", 32'(offs_at(0)), 32'd0);

        // randomized bursts
        for (int r = 0; r < 40; r++) begin
            mx = ($urandom_range(0, 3) == 0) ? 5 : 3;
            for (int i = 0; i < 4; i++) st[4*i +: 4] = 4'($urandom_range(0, mx));
            gl = int'($urandom_range(0, 4)) - 1;
            hl = int'($urandom_range(3, 28));
            ra = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, hl)) : -1;
            burst(st, int'($urandom_range(1, 12)), gl, int'($urandom_range(0, 6)),
                  int'($urandom_range(1, 6)), hl, 4'($urandom_range(0, 15)), ra, 1'b0);
        end

        @(negedge clk);
        chk_outputs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
